// File: rtl/shift_reg_seq_pkg.sv
// Shared definitions for the serial shift-register sequencer.
//   state_t     : FSM state encodings (IDLE=0 .. REPORT=4, 3 bits)
//   LOGIC_FALSE : single-bit constant 0
//   LOGIC_TRUE  : single-bit constant 1
//   cnt_width() : counter width helper (never smaller than one bit)
package shift_reg_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  localparam logic LOGIC_FALSE = 1'b0;
  localparam logic LOGIC_TRUE  = 1'b1;

  // Bits needed to hold values 0..n-1; a counter is at least one bit wide.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter with a zero flag.
//   clk_i      : clock, rising edge
//   srst_i     : synchronous active-high reset, clears the count
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one; holds at zero instead of wrapping
//   cnt_o      : current count
//   zero_o     : count is zero
module seq_down_counter #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         srst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/shift_reg_seq.sv
// Sequencer that serialises a parallel word into a DFF shift register.
// A captured word is presented MSB-first on SD, each bit strobed by one
// low-high SC period. After the last strobe the sequencer waits SETTLE
// cycles, compares the register taps against the word and pulses done.
//   C         : clock, rising edge
//   R         : synchronous active-high reset
//   start     : request, sampled only while idle
//   load_word : parallel word captured on the accepting edge
//   SD        : serial data to the register D input
//   SC        : shift clock to the register C input
//   Q_in      : register taps, [0] = first stage
//   busy      : accepting edge until done
//   done      : one-cycle end-of-operation pulse
//   match     : taps equalled the word at the sample point
module shift_reg_seq
  import shift_reg_seq_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic             C,
  input  logic             R,
  input  logic             start,
  input  logic [WIDTH-1:0] load_word,
  output logic             SD,
  output logic             SC,
  input  logic [WIDTH-1:0] Q_in,
  output logic             busy,
  output logic             done,
  output logic             match
);

  localparam int CNT_W  = cnt_width(WIDTH);
  localparam int WCNT_W = cnt_width(SETTLE);

  state_t           state_q;
  logic [WIDTH-1:0] wreg_q;
  logic             sd_q;
  logic             sc_q;
  logic             busy_q;
  logic             done_q;
  logic             match_q;

  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_zero;
  logic [WCNT_W-1:0] wcnt_val;
  logic              wcnt_zero;

  logic cnt_load;
  logic cnt_dec;
  logic wcnt_load;
  logic wcnt_dec;

  // Bit counter is loaded on accept and stepped once per strobe; the wait
  // counter is loaded on the final strobe and stepped through WAIT.
  always_comb begin
    cnt_load  = (state_q == ST_IDLE) && start;
    cnt_dec   = (state_q == ST_STROBE);
    wcnt_load = (state_q == ST_STROBE) && cnt_zero;
    wcnt_dec  = (state_q == ST_WAIT);
  end

  seq_down_counter #(.W(CNT_W)) u_bit_cnt (
    .clk_i      (C),
    .srst_i     (R),
    .load_i     (cnt_load),
    .load_val_i (CNT_W'(WIDTH - 1)),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt_val),
    .zero_o     (cnt_zero)
  );

  seq_down_counter #(.W(WCNT_W)) u_wait_cnt (
    .clk_i      (C),
    .srst_i     (R),
    .load_i     (wcnt_load),
    .load_val_i (WCNT_W'(SETTLE - 1)),
    .dec_i      (wcnt_dec),
    .cnt_o      (wcnt_val),
    .zero_o     (wcnt_zero)
  );

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= ST_IDLE;
      wreg_q  <= '0;
      sd_q    <= LOGIC_FALSE;
      sc_q    <= LOGIC_FALSE;
      busy_q  <= LOGIC_FALSE;
      done_q  <= LOGIC_FALSE;
      match_q <= LOGIC_FALSE;
    end else begin
      done_q <= LOGIC_FALSE;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            wreg_q  <= load_word;
            busy_q  <= LOGIC_TRUE;
            match_q <= LOGIC_FALSE;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // Data changes only while SC is low.
          sd_q    <= wreg_q[cnt_val];
          sc_q    <= LOGIC_FALSE;
          state_q <= ST_STROBE;
        end
        ST_STROBE: begin
          // SD is left untouched so it is stable across the SC rise.
          sc_q    <= LOGIC_TRUE;
          state_q <= cnt_zero ? ST_WAIT : ST_SETUP;
        end
        ST_WAIT: begin
          sc_q <= LOGIC_FALSE;
          sd_q <= LOGIC_FALSE;
          if (wcnt_zero) begin
            match_q <= (Q_in == wreg_q);
            state_q <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          done_q  <= LOGIC_TRUE;
          busy_q  <= LOGIC_FALSE;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // wait count value is only consumed through its zero flag
  logic unused_wcnt;
  assign unused_wcnt = ^wcnt_val;

  assign SD    = sd_q;
  assign SC    = sc_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign match = match_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
module tb_shift_reg_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] load_word;
  logic       sd;
  logic       sc;
  logic [1:0] q_in;
  logic       busy;
  logic       done;
  logic       match;

  // behavioural two-stage shift register driven by SD/SC
  logic       q1 = 1'b0;
  logic       q2 = 1'b0;
  logic       q_force = 1'b0;
  logic [1:0] q_force_val = 2'b00;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge sc) begin
    q1 <= sd;
    q2 <= q1;
  end

  assign q_in = q_force ? q_force_val : {q2, q1};

  shift_reg_seq #(.WIDTH(2), .SETTLE(1)) dut (
    .C         (clk),
    .R         (rst),
    .start     (start),
    .load_word (load_word),
    .SD        (sd),
    .SC        (sc),
    .Q_in      (q_in),
    .busy      (busy),
    .done      (done),
    .match     (match)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s observed=%0h", tag, obs);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    rst = 1'b1;
    start = 1'b1;
    load_word = 2'b11;
    #1;

    // reset held two edges with start high
    step();
    step();
    chk("rst_sd", sd, 0);
    chk("rst_sc", sc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_match", match, 0);
    rst = 1'b0;
    start = 1'b0;
    step();
    chk("rst_no_adv_busy", busy, 0);

    // nominal shift of 2'b10
    load_word = 2'b10;
    start = 1'b1;
    step();                       // edge t
    start = 1'b0;
    chk("nom_busy_t", busy, 1);
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k <= 4) begin
        chk($sformatf("nom_sd_t%0d", k), sd, (k <= 2) ? 1 : 0);
      end
      chk($sformatf("nom_sc_t%0d", k), sc, (k == 2 || k == 4) ? 1 : 0);
      chk($sformatf("nom_done_t%0d", k), done, (k == 6) ? 1 : 0);
      if (k == 6) begin
        chk("nom_match", match, 1);
        chk("nom_busy_t6", busy, 0);
        chk("nom_q", q_in, 2'b10);
      end
    end

    // mismatch: taps forced to 00 while 01 is shifted
    q_force = 1'b1;
    q_force_val = 2'b00;
    load_word = 2'b01;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k >= 5) chk($sformatf("mis_done_t%0d", k), done, (k == 6) ? 1 : 0);
    end
    chk("mis_match", match, 0);
    q_force = 1'b0;

    // start while busy: 11 accepted, 00 offered during operation
    load_word = 2'b11;
    start = 1'b1;
    step();                       // edge t
    load_word = 2'b00;
    dn = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 4) start = 1'b0;
      if (k == 1 || k == 3) chk($sformatf("busy_sd_t%0d", k), sd, 1);
      if (done) begin
        dn++;
        chk("busy_match", match, 1);
      end
    end
    chk("busy_done_count", dn, 1);

    // reset during the second STROBE cycle
    load_word = 2'b11;
    start = 1'b1;
    step();                       // edge t
    start = 1'b0;
    step();
    step();
    step();                       // cycle t+3: second STROBE
    rst = 1'b1;
    step();                       // edge t+4
    chk("mid_rst_sc", sc, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_match", match, 0);
    rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) dn++;
      step();
    end
    chk("mid_rst_done_count", dn, 0);

    // back-to-back with start held high
    load_word = 2'b10;
    start = 1'b1;
    step();                       // edge t
    load_word = 2'b01;
    dn = 0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 13) start = 1'b0;
      if (done) dn++;
      if (k == 6 || k == 13) begin
        chk($sformatf("b2b_done_t%0d", k), done, 1);
        chk($sformatf("b2b_match_t%0d", k), match, 1);
      end
      if (k == 6) chk("b2b_busy_t6", busy, 0);
      if (k == 7) chk("b2b_done_t7", done, 0);
      if (k == 13) chk("b2b_q", q_in, 2'b01);
    end
    chk("b2b_done_count", dn, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
